gen_rd_reg: RTL and testbench

- Host-side read-back register bank, the read counterpart of the general write register.
- The external MCU reads fabric status words over an asynchronous RE/RCLK strobe pair.
- The first qualified RCLK edge of a transaction snapshots all status inputs into a shadow bank. Each later edge advances through the words on RDATA.
- Sits between fabric status sources (counters, flags) and the MCU parallel bus.

---
 rtl/gen_rd_reg.sv | 173 +++++++++++++++++
 tb/tb_gen_rd_reg.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_rd_reg.sv
// gen_rd_reg: host read-back bank, snapshot on first RCLK edge, then stepped.
// Optional checksum word at index NREGS when GEN_RD_CSUM_EN is defined.
module gen_rd_reg #(
    parameter int NREGS = 4,
    parameter int DW    = 16,
    parameter int AW    = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NREGS*DW-1:0] STAT_IN,
    input  logic                RE,
    input  logic                RCLK,
    output logic [DW-1:0]       RDATA,
    output logic                RDY,
    output logic                WRAP,
    output logic [AW-1:0]       RPTR
);

`ifdef GEN_RD_CSUM_EN
    localparam int NW = NREGS + 1;
`else
    localparam int NW = NREGS;
`endif
    localparam logic [AW-1:0] LAST = AW'(NW - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_SHOW = 2'd2;

    logic          re_s1_q, re_s_q;
    logic          rck_s1_q, rck_s_q, rck_d_q;
    logic          rck_rise;
    logic [1:0]    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic          wrap_q, wrap_d;
    logic          rdy_q, rdy_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [DW-1:0] shadow_q [NW];
    logic [DW-1:0] shadow_sel;
    logic          snap;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            re_s1_q  <= 1'b0;
            re_s_q   <= 1'b0;
            rck_s1_q <= 1'b0;
            rck_s_q  <= 1'b0;
            rck_d_q  <= 1'b0;
        end else begin
            re_s1_q  <= RE;
            re_s_q   <= re_s1_q;
            rck_s1_q <= RCLK;
            rck_s_q  <= rck_s1_q;
            rck_d_q  <= rck_s_q;
        end
    end

    assign rck_rise = rck_s_q & ~rck_d_q;

    always_comb begin
        shadow_sel = '0;
        for (int k = 0; k < NW; k++) begin
            if (ptr_q == AW'(k)) shadow_sel = shadow_q[k];
        end
    end

`ifdef GEN_RD_CSUM_EN
    logic [DW-1:0] csum;

    always_comb begin
        csum = '0;
        for (int k = 0; k < NREGS; k++) begin
            csum = csum ^ STAT_IN[k*DW +: DW];
        end
    end
`endif

    // RDATA/RPTR lag the pointer by one cycle; RDY is low for that cycle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rptr_d  = rptr_q;
        wrap_d  = wrap_q;
        rdy_d   = rdy_q;
        rdata_d = rdata_q;
        snap    = 1'b0;
        if (!re_s_q) begin
            state_d = S_IDLE;
            ptr_d   = '0;
            rptr_d  = '0;
            wrap_d  = 1'b0;
            rdy_d   = 1'b0;
            rdata_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_ARM;
                    rdy_d   = 1'b1;
                    rdata_d = '0;
                end
                S_ARM: begin
                    rdata_d = '0;
                    rdy_d   = 1'b1;
                    if (rck_rise) begin
                        snap    = 1'b1;
                        ptr_d   = '0;
                        rdy_d   = 1'b0;
                        state_d = S_SHOW;
                    end
                end
                S_SHOW: begin
                    rdata_d = shadow_sel;
                    rptr_d  = ptr_q;
                    rdy_d   = ~rck_rise;
                    if (rck_rise) begin
                        if (ptr_q == LAST) begin
                            ptr_d  = '0;
                            wrap_d = 1'b1;
                        end else begin
                            ptr_d = ptr_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    ptr_d   = '0;
                    rptr_d  = '0;
                    wrap_d  = 1'b0;
                    rdy_d   = 1'b0;
                    rdata_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            rptr_q  <= '0;
            wrap_q  <= 1'b0;
            rdy_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rptr_q  <= rptr_d;
            wrap_q  <= wrap_d;
            rdy_q   <= rdy_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NW; k++) shadow_q[k] <= '0;
        end else if (snap) begin
            for (int k = 0; k < NREGS; k++) begin
                shadow_q[k] <= STAT_IN[k*DW +: DW];
            end
`ifdef GEN_RD_CSUM_EN
            shadow_q[NREGS] <= csum;
`endif
        end
    end

    assign RDATA = rdata_q;
    assign RDY   = rdy_q;
    assign WRAP  = wrap_q;
    assign RPTR  = rptr_q;

endmodule

// File: tb/tb_gen_rd_reg.sv
// Bench for gen_rd_reg: scoreboard of expected words vs RDY-qualified output.
`timescale 1ns/1ps
module tb_gen_rd_reg;
    localparam int NREGS = 4;
    localparam int DW    = 16;
`ifdef GEN_RD_CSUM_EN
    localparam int AW = 3;
    localparam int NW = NREGS + 1;
`else
    localparam int AW = 2;
    localparam int NW = NREGS;
`endif

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic [NREGS*DW-1:0] STAT_IN = '0;
    logic                RE = 1'b0;
    logic                RCLK = 1'b0;
    logic [DW-1:0]       RDATA;
    logic                RDY;
    logic                WRAP;
    logic [AW-1:0]       RPTR;

    gen_rd_reg #(.NREGS(NREGS), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rstn(rstn), .STAT_IN(STAT_IN), .RE(RE),
        .RCLK(RCLK), .RDATA(RDATA), .RDY(RDY), .WRAP(WRAP), .RPTR(RPTR)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [AW-1:0] p;
        logic          w;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    logic [DW-1:0] m_shadow [NW];
    int            m_idx = 0;
    bit            m_wrap = 0;
    bit            m_snapped = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    logic prev_rdy = 1'b0;
    always @(negedge clk) begin
        if (rstn && RDY && !prev_rdy) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_rdy: got data %h, nothing expected", RDATA);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rdata", 32'(RDATA), 32'(e.d));
                chk("rptr", 32'(RPTR), 32'(e.p));
                chk("wrap", 32'(WRAP), 32'(e.w));
            end
        end
        prev_rdy <= RDY;
    end

    function automatic logic [DW-1:0] word(input int k);
        return STAT_IN[k*DW +: DW];
    endfunction

    task automatic push_arm();
        exp_t e;
        e.d = '0;
        e.p = '0;
        e.w = 1'b0;
        sb.push_back(e);
        m_snapped = 0;
    endtask

    task automatic model_edge();
        exp_t e;
        logic [DW-1:0] x;
        if (!m_snapped) begin
            x = '0;
            for (int k = 0; k < NREGS; k++) begin
                m_shadow[k] = word(k);
                x = x ^ word(k);
            end
`ifdef GEN_RD_CSUM_EN
            m_shadow[NREGS] = x;
`endif
            m_idx = 0;
            m_wrap = 0;
            m_snapped = 1;
        end else begin
            m_idx = (m_idx + 1) % NW;
            if (m_idx == 0) m_wrap = 1;
        end
        e.d = m_shadow[m_idx];
        e.p = AW'(m_idx);
        e.w = m_wrap;
        sb.push_back(e);
    endtask

    task automatic pulse(input int hi, input int lo, input bit live);
        if (live) model_edge();
        @(negedge clk);
        RCLK = 1'b1;
        for (int i = 1; i <= hi; i++) begin
            @(negedge clk);
            if (live && i == 2) chk("rdy_before", 32'(RDY), 1);
            if (live && i == 3) chk("rdy_low", 32'(RDY), 0);
            if (live && i == 4) chk("rdy_back", 32'(RDY), 1);
            if (!live && i == 4) chk("ignored", 32'({RDY, RDATA}), 0);
        end
        RCLK = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic re_raise();
        @(negedge clk);
        push_arm();
        RE = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic re_drop();
        @(negedge clk);
        RE = 1'b0;
        repeat (3) @(negedge clk);
        chk("drop_rdata", 32'(RDATA), 0);
        chk("drop_flags", 32'({RDY, WRAP, RPTR}), 0);
        m_snapped = 0;
    endtask

    task automatic rand_stat();
        for (int k = 0; k < NREGS; k++) STAT_IN[k*DW +: DW] = DW'($urandom);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2 rstn = 1'b0;
        #1 chk("midrst_out", 32'({RDATA, RDY, WRAP, RPTR}), 0);
        repeat (2) @(negedge clk);
        push_arm();
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("requal_idle", 32'(RDY), 0);
        @(negedge clk);
        chk("requal_arm", 32'(RDY), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RE = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            RCLK = c[1];
            chk("reset_out", 32'({RDATA, RDY, WRAP, RPTR}), 0);
        end
        RCLK = 1'b0;
        for (int k = 0; k < NREGS; k++) begin
            STAT_IN[k*DW +: DW] = DW'(16'h1111 * (k + 1));
        end
        @(negedge clk);
        push_arm();
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", 32'(RDY), 0);
        @(negedge clk);
        chk("post_rst_rdy", 32'(RDY), 1);

        // basic read with isolation: word 1 changes after the snapshot
        pulse(4, 4, 1);
        STAT_IN[1*DW +: DW] = 16'hBEEF;
        for (int i = 1; i < NREGS; i++) pulse(4, 4, 1);
        re_drop();
        re_raise();
        pulse(4, 4, 1);
        pulse(4, 4, 1);
        chk("beef", 32'(RDATA), 32'h0000BEEF);
        re_drop();

        // wrap
        STAT_IN[1*DW +: DW] = 16'h2222;
        re_raise();
        for (int i = 0; i < NW; i++) pulse(4, 4, 1);
        chk("last_word", 32'(RDATA), 32'h00004444);
        pulse(4, 4, 1);
        chk("wrap_data", 32'(RDATA), 32'h00001111);
        chk("wrap_ptr", 32'(RPTR), 0);
        chk("wrap_flag", 32'(WRAP), 1);
        re_drop();

        // simultaneous RE fall and RCLK rise, then ignored edges
        re_raise();
        pulse(4, 4, 1);
        pulse(4, 4, 1);
        @(negedge clk);
        RE = 1'b0;
        RCLK = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_out", 32'({RDATA, RDY, WRAP, RPTR}), 0);
        RCLK = 1'b0;
        repeat (3) @(negedge clk);
        m_snapped = 0;
        pulse(4, 4, 0);
        re_raise();
        pulse(4, 4, 1);
        pulse(4, 3, 1);
        mid_reset();
        pulse(4, 4, 1);
        re_drop();

        // randomized transactions
        for (int t = 0; t < 8; t++) begin
            rand_stat();
            re_raise();
            for (int i = 0; i < int'($urandom_range(1, 2 * NW + 1)); i++) begin
                pulse($urandom_range(4, 6), $urandom_range(3, 6), 1);
                rand_stat();
            end
            if (t == 5) mid_reset();
            re_drop();
        end

        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
